mux_arbiter: RTL

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mux_arbiter.sv
// ============================================================================
// Module   : mux_arbiter
// Purpose  : 8-lane burst arbiter driving an 8-bit data mux; round-robin by
//            default, fixed lowest-index priority when ARB_FIXED_PRIO_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arbiter #(
   parameter int BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  req,
   input  logic [63:0] data_in,
   input  logic        out_ready,
   output logic [7:0]  out,
   output logic        out_valid,
   output logic [7:0]  gnt,
   output logic [2:0]  Sel,
   output logic        busy
);

   localparam logic [3:0] c_burst_max = 4'(BURST_MAX);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  sel_q, sel_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  gnt_q, gnt_d;
   logic        busy_q, busy_d;
   logic [2:0]  w_win;
   logic        w_xfer;
   logic        w_release;

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      w_win = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (req[k]) w_win = 3'(k);
      end
   end
`else
   logic [2:0] ptr_q, ptr_d;
   logic       w_found;
   logic [2:0] w_idx;

   // First requester at or above the pointer, wrapping 7 -> 0.
   always_comb begin
      w_win   = 3'd0;
      w_found = 1'b0;
      w_idx   = 3'd0;
      for (int k = 0; k < 8; k++) begin
         w_idx = ptr_q + 3'(k);
         if (!w_found && req[w_idx]) begin
            w_win   = w_idx;
            w_found = 1'b1;
         end
      end
   end
`endif

   assign out_valid = (state_q == ST_GRANT) && req[sel_q];
   assign out       = out_valid ? data_in[{sel_q, 3'b000} +: 8] : 8'h00;
   assign gnt       = gnt_q;
   assign Sel       = sel_q;
   assign busy      = busy_q;

   assign w_xfer    = out_valid && out_ready;
   // Backpressure alone never releases: only a final beat or a dropped request.
   assign w_release = (w_xfer && ((cnt_q + 4'd1) == c_burst_max)) || !req[sel_q];

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      if ((state_q == ST_IDLE) || w_release) begin
         cnt_d = 4'd0;
         if (|req) begin
            state_d = ST_GRANT;
            sel_d   = w_win;
`ifndef ARB_FIXED_PRIO_EN
            ptr_d   = w_win + 3'd1;
`endif
         end else begin
            state_d = ST_IDLE;
         end
      end else if (w_xfer) begin
         cnt_d = cnt_q + 4'd1;
      end
      gnt_d  = (state_d == ST_GRANT) ? (8'd1 << sel_d) : 8'd0;
      busy_d = (state_d == ST_GRANT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= 3'd0;
         cnt_q   <= 4'd0;
         gnt_q   <= 8'd0;
         busy_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q   <= 3'd0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

endmodule

`default_nettype wire
